// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Segment codes are active-high gfedcba; the top level applies board polarity.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SHIFT,
    FORMAT
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Hex digit table 0-F, gfedcba
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'h0: seg_digit = 7'h3F;
      4'h1: seg_digit = 7'h06;
      4'h2: seg_digit = 7'h5B;
      4'h3: seg_digit = 7'h4F;
      4'h4: seg_digit = 7'h66;
      4'h5: seg_digit = 7'h6D;
      4'h6: seg_digit = 7'h7D;
      4'h7: seg_digit = 7'h07;
      4'h8: seg_digit = 7'h7F;
      4'h9: seg_digit = 7'h6F;
      4'hA: seg_digit = 7'h77;
      4'hB: seg_digit = 7'h7C;
      4'hC: seg_digit = 7'h39;
      4'hD: seg_digit = 7'h5E;
      4'hE: seg_digit = 7'h79;
      default: seg_digit = 7'h71;
    endcase
  endfunction

  function automatic int unsigned bcd_w(input int unsigned nd);
    return 4 * nd;
  endfunction

  // Value width rounded up to nibbles, and at least as wide as the display
  function automatic int unsigned ext_w(input int unsigned vw, input int unsigned nd);
    int unsigned nib;
    nib = ((vw + 3) / 4) * 4;
    return (nib > 4 * nd) ? nib : 4 * nd;
  endfunction

endpackage

// File: rtl/seg_hex_encoder.sv
// Combinational 4-bit to active-high gfedcba segment encoder.
module seg_hex_encoder
  import seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_c
);

  assign seg_c = seg_digit(digit_i);

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment controller: hex or signed/unsigned decimal via serial double-dabble.
// Optional macro BLINK_EN adds blink_mask and a BLINK_DIV blink prescaler.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 16,
  parameter bit          ACTIVE_LOW = 1'b1
`ifdef BLINK_EN
  , parameter int unsigned BLINK_DIV = 25000000
`endif
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    mode,
  input  logic                    is_signed,
  input  logic                    blank_lz,
`ifdef BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [NUM_DIGITS*8-1:0] HEX
);

  localparam int unsigned BCD_W = bcd_w(NUM_DIGITS);
  localparam int unsigned EXT_W = ext_w(VALUE_W, NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(VALUE_W);
  localparam int unsigned HEX_W = NUM_DIGITS * 8;
  localparam logic [HEX_W-1:0] HEX_RST = ACTIVE_LOW ? {HEX_W{1'b1}} : {HEX_W{1'b0}};

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               mode_q, mode_d, sgn_q, sgn_d, blz_q, blz_d;
  logic [VALUE_W-1:0] mag_q, mag_d;
  logic               neg_q, neg_d, ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HEX_W-1:0]   hex_q, hex_d, fmt_hex;
  logic               busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic               fmt_ovf;

  logic [EXT_W-1:0]   mag_ext;
  logic [3:0]         nib [NUM_DIGITS];
  logic [6:0]         enc [NUM_DIGITS];

  assign mag_ext = EXT_W'(mag_q);

  // Per-digit value: BCD digit in decimal mode, value nibble in hex mode
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = mode_q ? bcd_q[4*i +: 4] : mag_ext[4*i +: 4];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg_hex_encoder u_enc (
      .digit_i (nib[g]),
      .seg_c   (enc[g])
    );
  end

  // Digit rendering: leading-zero blanking, minus placement, overflow pattern
  always_comb begin
    int unsigned ms;
    int unsigned minus_pos;
    logic [6:0]  code;
    ms        = 0;
    minus_pos = 0;
    code      = SEG_BLANK;
    fmt_hex   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (nib[i] != 4'd0) ms = i;
    end
    if (mode_q) fmt_ovf = ovf_q | (neg_q & (ms == NUM_DIGITS - 1));
    else        fmt_ovf = |(mag_ext >> (4 * NUM_DIGITS));
    minus_pos = blz_q ? ms + 1 : NUM_DIGITS - 1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      code = enc[i];
      if (blz_q && i > ms)                     code = SEG_BLANK;
      if (mode_q && neg_q && i == minus_pos)   code = SEG_MINUS;
      if (fmt_ovf)                             code = SEG_MINUS;
      fmt_hex[8*i +: 8] = ACTIVE_LOW ? ~{1'b0, code} : {1'b0, code};
    end
  end

  // Next-state and datapath. Load is sampled only in IDLE: a load on the
  // FORMAT edge is dropped, a load in the done cycle starts a new conversion.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    mode_d     = mode_q;
    sgn_d      = sgn_q;
    blz_d      = blz_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    bcd_adj    = bcd_q;
    cnt_d      = cnt_q;
    hex_d      = hex_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          value_d = value;
          mode_d  = mode;
          sgn_d   = is_signed;
          blz_d   = blank_lz;
          state_d = CAPT;
        end
      end
      CAPT: begin
        busy_d  = 1'b1;
        neg_d   = mode_q & sgn_q & value_q[VALUE_W-1];
        mag_d   = neg_d ? (~value_q + VALUE_W'(1)) : value_q;
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = mode_q ? SHIFT : FORMAT;
      end
      SHIFT: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[VALUE_W-1]};
        mag_d = {mag_q[VALUE_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = FORMAT;
      end
      FORMAT: begin
        hex_d      = fmt_hex;
        overflow_d = fmt_ovf;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      value_q    <= '0;
      mode_q     <= 1'b0;
      sgn_q      <= 1'b0;
      blz_q      <= 1'b0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      hex_q      <= HEX_RST;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      mode_q     <= mode_d;
      sgn_q      <= sgn_d;
      blz_q      <= blz_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

`ifdef BLINK_EN
  localparam int unsigned PRE_W = $clog2(BLINK_DIV + 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             phase_q, phase_d;

  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    phase_d = phase_q;
    if (pre_q == PRE_W'(BLINK_DIV - 1)) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  // Blink blanking sits after the output register
  always_comb begin
    HEX = hex_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (phase_q && blink_mask[i]) HEX[8*i +: 8] = ACTIVE_LOW ? 8'hFF : 8'h00;
    end
  end
`else
  assign HEX = hex_q;
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: hand vectors, corner sequences and
// random transactions against an arithmetic reference model (6- and 5-digit DUTs).
module tb_seg_display_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        is_signed = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0;

  logic        busy6, done6, ovf6;
  logic        busy5, done5, ovf5;
  logic [47:0] hex6;
  logic [39:0] hex5;

  int n_cmp = 0;
  int n_fail = 0;

  // Board-polarity digit codes 0-F with dp off
  logic [7:0] segs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_display_ctrl #(.NUM_DIGITS(6), .VALUE_W(16), .ACTIVE_LOW(1'b1)) dut6 (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .value(value), .mode(mode),
    .is_signed(is_signed), .blank_lz(blank_lz),
    .busy(busy6), .done(done6), .overflow(ovf6), .HEX(hex6)
  );

  seg_display_ctrl #(.NUM_DIGITS(5), .VALUE_W(16), .ACTIVE_LOW(1'b1)) dut5 (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .value(value), .mode(mode),
    .is_signed(is_signed), .blank_lz(blank_lz),
    .busy(busy5), .done(done5), .overflow(ovf5), .HEX(hex5)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected display computed from the display rules with plain arithmetic
  function automatic void model(input logic [15:0] v, input bit m, input bit s, input bit b,
                                input int nd, output logic [47:0] hx, output bit ov);
    int  digs [8];
    int  mag, lim, p, nsig;
    bit  neg;
    logic [7:0] code;
    hx  = '1;
    neg = 1'b0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (!m) begin
      for (int i = 0; i < nd; i++) digs[i] = (32'(v) >> (4 * i)) & 15;
      ov = (32'(v) >> (4 * nd)) != 0;
    end else begin
      neg = s && v[15];
      mag = 32'(v);
      if (neg) mag = 65536 - mag;
      ov = (mag >= lim) || (neg && mag >= lim / 10);
      p = 1;
      for (int i = 0; i < nd; i++) begin
        digs[i] = (mag / p) % 10;
        p = p * 10;
      end
    end
    nsig = 1;
    for (int i = 0; i < nd; i++) if (digs[i] != 0) nsig = i + 1;
    for (int i = 0; i < nd; i++) begin
      code = segs[digs[i]];
      if (b && i >= nsig) code = 8'hFF;
      if (neg && i == (b ? nsig : nd - 1)) code = 8'hBF;
      if (ov) code = 8'hBF;
      hx[8*i +: 8] = code;
    end
  endfunction

  task automatic wait_done(output int cyc, output int nbusy, input int start);
    cyc   = start;
    nbusy = 0;
    while (!done6 && cyc < 200) begin
      if (busy6) nbusy++;
      @(negedge Clk);
      cyc++;
    end
  endtask

  task automatic run_txn(input logic [15:0] v, input bit m, input bit s, input bit b,
                         input logic [47:0] hx, input bit ov, input string name);
    logic [47:0] hx5;
    bit          ov5;
    int          cyc, nbusy;
    model(v, m, s, b, 5, hx5, ov5);
    @(negedge Clk);
    value = v; mode = m; is_signed = s; blank_lz = b; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_done(cyc, nbusy, 0);
    check({name, " latency"}, 64'(cyc), m ? 64'd18 : 64'd2);
    check({name, " busy_cycles"}, 64'(nbusy), m ? 64'd17 : 64'd1);
    check({name, " busy_in_done"}, 64'(busy6), 64'd0);
    check({name, " hex6"}, 64'(hex6), 64'(hx));
    check({name, " ovf6"}, 64'(ovf6), 64'(ov));
    check({name, " done5"}, 64'(done5), 64'd1);
    check({name, " hex5"}, 64'(hex5), 64'(hx5[39:0]));
    check({name, " ovf5"}, 64'(ovf5), 64'(ov5));
    @(negedge Clk);
    check({name, " done_pulse"}, 64'(done6), 64'd0);
  endtask

  typedef struct {
    logic [15:0] v;
    bit          m;
    bit          s;
    bit          b;
    logic [47:0] hx;
    bit          ov;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [47:0] hx;
    bit          ov;
    logic [15:0] rv;
    int          cyc, nbusy, ndone;

    vecs[0] = '{16'h1A3F, 1'b0, 1'b0, 1'b1, 48'hFFFF_F988_B08E, 1'b0};
    vecs[1] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 48'hC082_9292_B092, 1'b0};
    vecs[2] = '{16'hFF85, 1'b1, 1'b1, 1'b1, 48'hFFFF_BFF9_A4B0, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFC0, 1'b0};
    vecs[4] = '{16'h0000, 1'b1, 1'b1, 1'b0, 48'hC0C0_C0C0_C0C0, 1'b0};
    vecs[5] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 48'hBFC0_C0C0_C0F9, 1'b0};
    vecs[6] = '{16'h8000, 1'b0, 1'b1, 1'b0, 48'hC0C0_80C0_C0C0, 1'b0};
    vecs[7] = '{16'h3039, 1'b1, 1'b0, 1'b1, 48'hFFF9_A4B0_9992, 1'b0};
    vecs[8] = '{16'h8000, 1'b1, 1'b1, 1'b0, 48'hBFB0_A4F8_8280, 1'b0};

    repeat (3) @(negedge Clk);
    check("reset hex6", 64'(hex6), 64'hFFFF_FFFF_FFFF);
    check("reset hex5", 64'(hex5), 64'hFF_FFFF_FFFF);
    check("reset busy", 64'(busy6), 64'd0);
    check("reset done", 64'(done6), 64'd0);
    check("reset ovf", 64'(ovf6), 64'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].v, vecs[i].m, vecs[i].s, vecs[i].b, vecs[i].hx, vecs[i].ov, "vec");
    end
    check("min_neg nd5 ovf", 64'(ovf5), 64'd1);
    check("min_neg nd5 hex", 64'(hex5), 64'hBF_BFBF_BFBF);

    // Reset in the middle of a decimal conversion
    @(negedge Clk);
    value = 16'd999; mode = 1'b1; is_signed = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midrst hex6", 64'(hex6), 64'hFFFF_FFFF_FFFF);
    check("midrst busy", 64'(busy6), 64'd0);
    check("midrst done", 64'(done6), 64'd0);
    check("midrst ovf5", 64'(ovf5), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge Clk);
      if (done6 || busy6) ndone++;
    end
    check("midrst stays idle", 64'(ndone), 64'd0);
    check("midrst hex held", 64'(hex6), 64'hFFFF_FFFF_FFFF);

    // Second load while shifting is ignored
    @(negedge Clk);
    value = 16'd1234; mode = 1'b1; is_signed = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    cyc = 0;
    repeat (5) begin
      @(negedge Clk);
      cyc++;
    end
    value = 16'd9999; load = 1'b1;
    @(negedge Clk);
    cyc++;
    load = 1'b0;
    wait_done(cyc, nbusy, cyc);
    model(16'd1234, 1'b1, 1'b0, 1'b0, 6, hx, ov);
    check("busyload latency", 64'(cyc), 64'd18);
    check("busyload hex6", 64'(hex6), 64'(hx));
    ndone = 0;
    repeat (25) begin
      @(negedge Clk);
      if (done6) ndone++;
    end
    check("busyload no second done", 64'(ndone), 64'd0);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       rv = 16'h8000;
        1:       rv = 16'hFFFF;
        2:       rv = 16'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 9999) : 0);
        default: rv = 16'($urandom);
      endcase
      model(rv, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 1) != 0, 6, hx, ov);
      begin
        bit m, s, b;
        m = $urandom_range(0, 1) != 0;
        s = $urandom_range(0, 1) != 0;
        b = $urandom_range(0, 1) != 0;
        model(rv, m, s, b, 6, hx, ov);
        run_txn(rv, m, s, b, hx, ov, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
